// File: rtl/parity_sched_pkg.sv
// Shared types and defaults for the round-robin parity scheduler.
package parity_sched_pkg;
  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parity_sched_if.sv
// Request/result bundle of parity_sched. With PARITY_CHECK_EN defined it also
// carries the expected-parity input and the parity-error output.
interface parity_sched_if import parity_sched_pkg::*; #(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_par;
  logic [ID_W-1:0]         res_id;
  logic                    busy;
`ifdef PARITY_CHECK_EN
  logic [N_REQ-1:0]        req_exp;
  logic                    res_err;

  modport master (output req_valid, req_data, req_exp, res_ready,
                  input  req_ready, res_valid, res_par, res_id, res_err, busy);
  modport slave  (input  req_valid, req_data, req_exp, res_ready,
                  output req_ready, res_valid, res_par, res_id, res_err, busy);
`else
  modport master (output req_valid, req_data, res_ready,
                  input  req_ready, res_valid, res_par, res_id, busy);
  modport slave  (input  req_valid, req_data, res_ready,
                  output req_ready, res_valid, res_par, res_id, busy);
`endif
endinterface

// File: rtl/parity_serial_core.sv
// Bit-serial XOR engine: shift register, parity accumulator and bit counter.
module parity_serial_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              step_i,
  output logic              last_o,
  output logic              par_o
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      acc_d = 1'b0;
      cnt_d = '0;
    end else if (step_i) begin
      sh_d  = sh_q >> 1;
      acc_d = acc_q ^ sh_q[0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));
  assign par_o  = acc_q;
endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one bit-serial parity engine among N_REQ
// requesters. Optional expected-parity check under PARITY_CHECK_EN.
module parity_sched import parity_sched_pkg::*; #(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  parity_sched_if.slave bus
);
  localparam int ID_W = id_w(N_REQ);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic            any_vld;
  logic            load, step, last, par, res_fire;
  logic            res_par_q;
  logic [ID_W-1:0] res_id_q;
`ifdef PARITY_CHECK_EN
  logic            exp_q, res_err_q;
`endif

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    any_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_vld && bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        any_vld = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    gnt = any_vld ? (N_REQ'(1) << gnt_id) : '0;
  end

  assign ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

  parity_serial_core #(.DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (bus.req_data[gnt_id*DATA_W +: DATA_W]),
    .step_i (step),
    .last_o (last),
    .par_o  (par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_vld)       state_d = ST_SHIFT;
      ST_SHIFT: if (last)          state_d = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Result outputs track live registers in DONE and hold the last delivered
  // values elsewhere, so they never show a half-computed job.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
    bus.busy      = (state_q != ST_IDLE);
    bus.res_valid = (state_q == ST_DONE);
    load          = (state_q == ST_IDLE) && any_vld;
    step          = (state_q == ST_SHIFT);
    res_fire      = (state_q == ST_DONE) && bus.res_ready;
    bus.res_par   = (state_q == ST_DONE) ? par  : res_par_q;
    bus.res_id    = (state_q == ST_DONE) ? id_q : res_id_q;
`ifdef PARITY_CHECK_EN
    bus.res_err   = (state_q == ST_DONE) ? (par ^ exp_q) : res_err_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      id_q      <= '0;
      res_par_q <= 1'b0;
      res_id_q  <= '0;
`ifdef PARITY_CHECK_EN
      exp_q     <= 1'b0;
      res_err_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        id_q  <= gnt_id;
`ifdef PARITY_CHECK_EN
        exp_q <= bus.req_exp[gnt_id];
`endif
      end
      if (res_fire) begin
        ptr_q     <= ptr_d;
        res_par_q <= par;
        res_id_q  <= id_q;
`ifdef PARITY_CHECK_EN
        res_err_q <= par ^ exp_q;
`endif
      end
    end
  end
endmodule

// File: doc/parity_sched.md
# parity_sched

Round-robin scheduler that shares one bit-serial parity engine among `N_REQ` requesters. Each requester hands over a `DATA_W`-bit word with a valid/ready handshake. The block computes the word's XOR parity one bit per cycle, then returns the result and the requester ID on a valid/ready result port. It sits between several producers (UART/packet framers) and the single parity resource, replacing per-requester combinational parity trees.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `DATA_W`, default 8: word width, ≥2.
- `clk` in, 1: rising-edge clock.
- `rst` in, 1: asynchronous, active-high reset.
- `req_valid` in, `N_REQ`: per-requester request.
- `req_data` in, `N_REQ*DATA_W`: requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out, `N_REQ`: one-hot grant/accept.
- `res_valid` out, 1: result available.
- `res_ready` in, 1: consumer accepts result.
- `res_par` out, 1: XOR of all word bits. 1 means an odd number of ones; 0 means even.
- `res_id` out, `$clog2(N_REQ)`: index of the requester that was served.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: bit-serial accumulation.
  - DONE: result held.
- IDLE:
  - If any `req_valid` is high, the arbiter picks the first valid index at or after `ptr`, wrapping modulo `N_REQ`.
  - `req_ready[g]` = (state==IDLE) & grant[g]. It is combinational and at most one bit is high.
  - On that edge the block captures the word into the shift register, clears the accumulator, sets `id`=g and `cnt`=0, and moves to SHIFT.
- SHIFT:
  - Each cycle: `acc` ^= `sh[0]`, `sh` >>= 1, `cnt`++.
  - After `DATA_W` shift edges (`cnt`==`DATA_W`-1 on the last one), move to DONE.
- DONE:
  - `res_valid`=1. `res_par`/`res_id` are driven from registers.
  - On `res_valid`&`res_ready`: move to IDLE and set `ptr` = (id+1) mod `N_REQ`.
- `req_ready` is 0 in SHIFT and DONE. Requests stay pending, and requesters must hold `req_valid` and `req_data` stable until they are accepted.
- Changes on `req_valid`/`req_data` after acceptance have no effect.
- `res_par`/`res_id` are valid only while `res_valid`=1. Outside DONE they hold their last value.

## Timing
- Reset values: state=IDLE, `ptr`=0, `req_ready`=0 (no valid is possible in reset), `res_valid`=0, `res_par`=0, `res_id`=0, `busy`=0, `acc`=0, `cnt`=0.
- Latency: if acceptance occurs at edge T, `res_valid` rises after edge T+`DATA_W`.
- Best-case throughput: one word per `DATA_W`+2 cycles (IDLE + `DATA_W` SHIFT + DONE with `res_ready`=1).
- Under backpressure, DONE holds indefinitely and all result outputs stay stable.
- Simultaneous requests are resolved by the round-robin rule only. No requester waits more than `N_REQ`-1 services.
- Asynchronous reset in any state aborts the job immediately:
  - No result is produced.
  - The aborted requester is not considered served, so it re-requests.

## Configuration
- `PARITY_CHECK_EN` defined:
  - Adds input `req_exp` (`N_REQ`) and output `res_err` (1).
  - `req_exp[g]` is captured at acceptance.
  - `res_err` = `acc` ^ `exp`, valid with `res_valid`, reset value 0.
- Not defined: the `req_exp` and `res_err` ports and their registers do not exist. Result behaviour is otherwise identical.

## Structure
- Package `parity_sched_pkg`:
  - state enum (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`).
  - default `N_REQ`/`DATA_W` constants.
  - a helper for ID width.
- Sub-module `parity_serial_core`:
  - contains the shift register, accumulator and bit counter.
  - interface: `load`, `data`, `step`, `last`, `par`.
  - The top level holds the arbiter, pointer, FSM and handshakes.

## Test plan
All scenarios use `N_REQ`=4 and `DATA_W`=8.
1. Only requester 0 valid, data 0x07:
   - `req_ready`=0001 in the same cycle.
   - `res_valid` high 8 cycles after acceptance.
   - `res_par`=1, `res_id`=0.
2. After reset, all four valid with data 0x00, 0x01, 0x03, 0xFF:
   - Served in order 0, 1, 2, 3.
   - `res_par` = 0, 1, 0, 0.
3. `res_ready` held low for 5 cycles in DONE:
   - `res_valid`, `res_par` and `res_id` stay constant.
   - `req_ready` stays 0000.
   - The transfer completes on the cycle `res_ready` rises.
4. Round-robin wrap: last served ID 2, then requesters 0 and 3 valid:
   - 3 is granted first, then 0.
5. `rst` pulsed at the 4th SHIFT cycle:
   - All outputs are at reset values immediately.
   - No `res_valid` appears.
   - A resubmitted 0x55 returns `res_par`=0.
6. `PARITY_CHECK_EN` defined:
   - Data 0x07 with `exp`=0 gives `res_err`=1.
   - Data 0x07 with `exp`=1 gives `res_err`=0.
